stream_mmio_bank: RTL
=====================

STREAM_MMIO_BANK -- requirements
Module: stream_mmio_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 5: number of stream channels in each direction (1..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32: stream word width (8..32).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: entries per FIFO, power of two, minimum 2.
REQ-004 SHALL have parameter BLOCKING, default 1: 1 = stall the bus on a full or empty FIFO; 0 = complete immediately and set the sticky error flag.
REQ-005 SHALL have parameter BASE_ADDR, default 32'h2000_0000: base of the channel register window.
REQ-006 SHALL have parameter PRINT_ADDR, default 32'h1000_0000: console byte register.
REQ-007 SHALL have ports in this order: clk in 1 (clock); resetn in 1 (synchronous, active-low reset).
REQ-008 SHALL have bus ports: mem_valid in 1; mem_addr in 32; mem_wdata in 32; mem_wstrb in 4; mem_ready out 1; mem_rdata out 32.
REQ-009 SHALL have TX stream ports: val_out out NUM_CH; ready_downward in NUM_CH; dout out NUM_CH*DATA_WIDTH.
REQ-010 SHALL have RX stream ports: val_in in NUM_CH; ready_upward out NUM_CH; din in NUM_CH*DATA_WIDTH.
REQ-011 SHALL have port print_out out 49, the console event bus.
REQ-012 SHALL place channel c at bit c of 1-bit vectors and at bits [c*DATA_WIDTH +: DATA_WIDTH] of data buses.

Function
REQ-013 SHALL decode addresses per channel: TXDATA = BASE_ADDR+c*16+0 (write), RXDATA = +4 (read, pops), STATUS = +8 (read), ERRCLR = +12 (write clears the error flag).
REQ-014 SHALL not respond to accesses outside the window or PRINT_ADDR: mem_ready stays 0, with no side effects.
REQ-015 SHALL use a bus FSM with states IDLE, WAIT, RESP.
- IDLE to RESP on a decoded access that can complete.
- IDLE to WAIT on a blocked access (only when BLOCKING=1).
- WAIT to RESP when the FIFO condition clears.
- RESP to IDLE unconditionally.
REQ-016 SHALL assert mem_ready for exactly one cycle, in RESP; minimum latency is 1 cycle after mem_valid is sampled in IDLE.
REQ-017 SHALL, on a TXDATA write, push mem_wdata[DATA_WIDTH-1:0] into TX FIFO c; the push occurs on the IDLE-to-RESP or WAIT-to-RESP edge.
REQ-018 SHALL, on an RXDATA read, pop RX FIFO c and drive the zero-extended head onto mem_rdata during RESP.
REQ-019 SHALL hold mem_rdata at 0 whenever mem_ready is 0.
REQ-020 SHALL form STATUS as {16'b0, rx_count[7:0], tx_count[5:0], err, rx_empty_n}, with tx_full placed at bit 0 of tx_count's MSB-extension.
REQ-021 SHALL encode STATUS fields in a package constant; the bit positions SHALL be identical in RTL and bench.
REQ-022 SHALL, with BLOCKING=0, complete a write to a full TX FIFO without pushing and set err[c].
REQ-023 SHALL, with BLOCKING=0, complete a read of an empty RX FIFO with rdata 0 and set err[c].
REQ-024 SHALL evaluate full/empty from registered FIFO state; a simultaneous stream pop does not unblock the same-cycle bus push, and vice versa.
REQ-025 SHALL drive val_out[c] = TX FIFO c non-empty and dout = TX head; a pop occurs when val_out & ready_downward.
REQ-026 SHALL drive ready_upward[c] = RX FIFO c not full; a push occurs when val_in & ready_upward.
REQ-027 SHALL allow a FIFO push and pop in the same cycle when neither full nor empty; the count is then unchanged.
REQ-028 SHALL use wrap-around read/write pointers with an extra MSB for full/empty disambiguation.
REQ-029 SHALL, on a PRINT_ADDR write with mem_wstrb[0]=1, drive print_out = {1'b1, 40'b0, mem_wdata[7:0]} for exactly one cycle, coincident with mem_ready; print_out is 0 otherwise.
REQ-030 SHALL ignore mem_wstrb for TXDATA: any nonzero strobe pushes the full word.
REQ-031 SHALL treat mem_wstrb = 0 as a read.

Reset
REQ-032 SHALL, when resetn=0 at a clk edge, clear FSM to IDLE, all FIFO pointers, all err bits, mem_ready, mem_rdata and print_out.
REQ-033 SHALL make val_out and ready_upward reflect empty FIFOs the cycle after reset: val_out=0, ready_upward=all ones.
REQ-034 SHALL abort a WAIT-state transaction on reset mid-operation, with no push, no pop and no mem_ready.

Structure
REQ-035 SHALL define register offsets, STATUS bit positions and FSM state encoding in package stream_mmio_pkg.
REQ-036 SHALL implement each FIFO as an instance of sub-module stream_fifo (params WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count), instantiated 2*NUM_CH times.

Verification
REQ-037 SHALL cover this scenario: write 0xA5A5_0001 to TXDATA ch2 with ready_downward[2]=1; mem_ready 1 cycle later, then val_out[2]=1 with dout ch2=0xA5A5_0001 for one cycle.
REQ-038 SHALL cover this scenario: BLOCKING=1, ready_downward=0, 5 writes to ch0 with FIFO_DEPTH=4; the 5th stalls in WAIT until ready_downward[0] pulses once, then completes.
REQ-039 SHALL cover this scenario: BLOCKING=0, read RXDATA ch1 while empty; mem_rdata=0, then STATUS ch1 err bit=1, and a write to ERRCLR clears it.
REQ-040 SHALL cover this scenario: push 4 words on din ch4 with val_in held; ready_upward[4] drops after the 4th; RXDATA reads return the words in order, and ready_upward rises after the first pop.
REQ-041 SHALL cover this scenario: write 0x41 to PRINT_ADDR; print_out = 49'h1_0000_0000_0041 for one cycle, then 0.
REQ-042 SHALL cover this scenario: assert resetn=0 during a blocked write; no push occurs, mem_ready never pulses, and all outputs are at reset values next cycle.

Source files
------------

// File: rtl/stream_mmio_pkg.sv
// Shared register map, STATUS bit layout and bus FSM encoding for the stream MMIO bank.
package stream_mmio_pkg;

  localparam logic [3:0] OffTxData = 4'h0;
  localparam logic [3:0] OffRxData = 4'h4;
  localparam logic [3:0] OffStatus = 4'h8;
  localparam logic [3:0] OffErrClr = 4'hC;

  localparam int unsigned StatRxNempty = 0;
  localparam int unsigned StatErr      = 1;
  localparam int unsigned StatTxCntLsb = 2;
  localparam int unsigned StatRxCntLsb = 8;

  // Channel select field width inside the 16-byte-per-channel window (up to 8 channels).
  localparam int unsigned ChIdxW = 3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } bus_state_e;

  typedef enum logic [2:0] {
    OpNop,
    OpTx,
    OpRx,
    OpStatus,
    OpErrClr,
    OpPrint
  } bus_op_e;

  // tx_fld carries the TX count with tx_full in the first bit above the count.
  function automatic logic [31:0] status_word(input logic [7:0] rx_cnt, input logic [5:0] tx_fld,
                                              input logic err, input logic rx_nempty);
    logic [31:0] w;
    w                       = '0;
    w[StatRxCntLsb +: 8]    = rx_cnt;
    w[StatTxCntLsb +: 6]    = tx_fld;
    w[StatErr]              = err;
    w[StatRxNempty]         = rx_nempty;
    return w;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Power-of-two FIFO with wrap-around pointers carrying an extra MSB for full/empty.
module stream_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] PtrOne = 1;

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count   = wptr_q - rptr_q;
  assign dout    = mem_q[rptr_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/stream_mmio_bank.sv
// Memory-mapped bank of TX/RX stream FIFOs plus a console byte register on a valid/ready bus.
module stream_mmio_bank
  import stream_mmio_pkg::*;
#(
  parameter int unsigned NUM_CH     = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BLOCKING   = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
  parameter logic [31:0] PRINT_ADDR = 32'h1000_0000
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         mem_valid,
  input  logic [31:0]                  mem_addr,
  input  logic [31:0]                  mem_wdata,
  input  logic [3:0]                   mem_wstrb,
  output logic                         mem_ready,
  output logic [31:0]                  mem_rdata,
  output logic [NUM_CH-1:0]            val_out,
  input  logic [NUM_CH-1:0]            ready_downward,
  output logic [NUM_CH*DATA_WIDTH-1:0] dout,
  input  logic [NUM_CH-1:0]            val_in,
  output logic [NUM_CH-1:0]            ready_upward,
  input  logic [NUM_CH*DATA_WIDTH-1:0] din,
  output logic [48:0]                  print_out
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_CH-1:0]     tx_push, tx_full, tx_empty, rx_pop, rx_full, rx_empty;
  logic [CntW-1:0]       tx_cnt [NUM_CH];
  logic [CntW-1:0]       rx_cnt [NUM_CH];
  logic [DATA_WIDTH-1:0] rx_head [NUM_CH];

  bus_state_e        state_q, state_d;
  bus_op_e           op_q, dec_op, cur_op;
  logic [ChIdxW-1:0] ch_q, dec_ch, cur_ch;
  logic [31:0]       wdata_q, cur_wdata, offset, rdata_d, mem_rdata_q;
  logic [48:0]       print_d, print_q;
  logic [NUM_CH-1:0] err_d, err_q;
  logic              in_window, is_write, hit, blocked, fire;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    stream_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx (
      .clk   (clk),
      .resetn(resetn),
      .push  (tx_push[c]),
      .pop   (ready_downward[c]),
      .din   (cur_wdata[DATA_WIDTH-1:0]),
      .dout  (dout[c*DATA_WIDTH +: DATA_WIDTH]),
      .full  (tx_full[c]),
      .empty (tx_empty[c]),
      .count (tx_cnt[c])
    );
    stream_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx (
      .clk   (clk),
      .resetn(resetn),
      .push  (val_in[c]),
      .pop   (rx_pop[c]),
      .din   (din[c*DATA_WIDTH +: DATA_WIDTH]),
      .dout  (rx_head[c]),
      .full  (rx_full[c]),
      .empty (rx_empty[c]),
      .count (rx_cnt[c])
    );
  end

  assign val_out      = ~tx_empty;
  assign ready_upward = ~rx_full;
  assign mem_ready    = (state_q == StResp);
  assign mem_rdata    = mem_rdata_q;
  assign print_out    = print_q;

  // Unsigned wrap makes addresses below BASE_ADDR fall outside the window too.
  assign offset    = mem_addr - BASE_ADDR;
  assign in_window = offset < 32'(NUM_CH * 16);
  assign dec_ch    = offset[4 +: ChIdxW];
  assign is_write  = |mem_wstrb;

  always_comb begin
    dec_op = OpNop;
    hit    = 1'b0;
    if (mem_addr == PRINT_ADDR) begin
      hit = 1'b1;
      if (is_write && mem_wstrb[0]) dec_op = OpPrint;
    end else if (in_window) begin
      hit = 1'b1;
      case ({offset[3:2], 2'b00})
        OffTxData: dec_op = is_write ? OpTx : OpNop;
        OffRxData: dec_op = is_write ? OpNop : OpRx;
        OffStatus: dec_op = is_write ? OpNop : OpStatus;
        OffErrClr: dec_op = is_write ? OpErrClr : OpNop;
        default:   dec_op = OpNop;
      endcase
    end
  end

  // A stalled transaction runs from the copy latched when it left IDLE.
  assign cur_op    = (state_q == StWait) ? op_q : dec_op;
  assign cur_ch    = (state_q == StWait) ? ch_q : dec_ch;
  assign cur_wdata = (state_q == StWait) ? wdata_q : mem_wdata;
  assign blocked   = ((cur_op == OpTx) && tx_full[cur_ch]) || ((cur_op == OpRx) && rx_empty[cur_ch]);

  always_comb begin
    state_d = state_q;
    fire    = 1'b0;
    case (state_q)
      StIdle: begin
        if (mem_valid && hit) begin
          if (blocked && (BLOCKING != 0)) begin
            state_d = StWait;
          end else begin
            state_d = StResp;
            fire    = 1'b1;
          end
        end
      end
      StWait: begin
        if (!blocked) begin
          state_d = StResp;
          fire    = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_push = '0;
    rx_pop  = '0;
    err_d   = err_q;
    rdata_d = '0;
    print_d = '0;
    if (fire) begin
      case (cur_op)
        OpTx: begin
          if (blocked) err_d[cur_ch] = 1'b1;
          else         tx_push[cur_ch] = 1'b1;
        end
        OpRx: begin
          if (blocked) begin
            err_d[cur_ch] = 1'b1;
          end else begin
            rx_pop[cur_ch] = 1'b1;
            rdata_d        = 32'(rx_head[cur_ch]);
          end
        end
        OpStatus: rdata_d = status_word(8'(rx_cnt[cur_ch]),
                                        6'(tx_cnt[cur_ch]) | (6'(tx_full[cur_ch]) << CntW),
                                        err_q[cur_ch], !rx_empty[cur_ch]);
        OpErrClr: err_d[cur_ch] = 1'b0;
        OpPrint:  print_d = {1'b1, 40'b0, cur_wdata[7:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      op_q        <= OpNop;
      ch_q        <= '0;
      wdata_q     <= '0;
      err_q       <= '0;
      mem_rdata_q <= '0;
      print_q     <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      mem_rdata_q <= rdata_d;
      print_q     <= print_d;
      if (state_q == StIdle) begin
        op_q    <= dec_op;
        ch_q    <= dec_ch;
        wdata_q <= mem_wdata;
      end
    end
  end

endmodule
